// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-stage control: opcodes, writeback source
// encodings and the sequencer state type.
package wb_pkg;

  localparam logic [3:0] OP_ADI = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_JAL = 4'b1001;
  localparam logic [3:0] OP_JLR = 4'b1010;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC2 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWalk = 1'b1
  } wb_state_e;

endpackage

// File: rtl/lm_mask_scan.sv
// Combinational lowest-set-bit finder for LM register masks; also returns the
// mask with that bit cleared so the caller can keep walking.
module lm_mask_scan #(
  parameter int unsigned MASK_W = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [MASK_W-1:0] mask_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [MASK_W-1:0] mask_clr_o
);

  always_comb begin
    found_o    = |mask_i;
    idx_o      = '0;
    // Descending scan so the lowest set bit is the last one to win.
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
    mask_clr_o = mask_i & (mask_i - MASK_W'(1));
  end

endmodule

// File: rtl/wb_control_unit.sv
// Writeback-stage control: registered decode of the MEM/WB instruction into
// register-file write controls, plus a one-register-per-cycle LM walker.
module wb_control_unit
  import wb_pkg::*;
#(
  parameter int unsigned IR_W   = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              mem_wb_valid,
  input  logic [IR_W-1:0]   mem_wb_ir,
  output logic              wb_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [1:0]        wb_src_sel,
  output logic [REG_AW-1:0] lm_offset
);

  wb_state_e         state_q, state_d;
  logic [MASK_W-1:0] rem_q, rem_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [1:0]        sel_q, sel_d;
  logic [REG_AW-1:0] off_q, off_d;

  logic [OP_W-1:0]   opcode;
  logic              accept;
  logic [MASK_W-1:0] scan_mask;
  logic              scan_found;
  logic [REG_AW-1:0] scan_idx;
  logic [MASK_W-1:0] scan_clr;

  assign opcode = mem_wb_ir[IR_W-1 -: OP_W];
  assign accept = mem_wb_valid && (state_q == StIdle);

  // One scanner serves both the first LM write (fresh mask) and the walk.
  assign scan_mask = (state_q == StWalk) ? rem_q : mem_wb_ir[MASK_W-1:0];

  lm_mask_scan #(
    .MASK_W (MASK_W),
    .IDX_W  (REG_AW)
  ) u_lm_mask_scan (
    .mask_i     (scan_mask),
    .found_o    (scan_found),
    .idx_o      (scan_idx),
    .mask_clr_o (scan_clr)
  );

  always_comb begin
    state_d = StIdle;
    rem_d   = '0;
    we_d    = 1'b0;
    waddr_d = '0;
    sel_d   = WB_ALU;
    off_d   = '0;

    if (flush) begin
      // Kill: defaults already describe an idle, non-writing stage.
    end else if (state_q == StWalk) begin
      if (scan_found) begin
        we_d    = 1'b1;
        waddr_d = scan_idx;
        sel_d   = WB_MEM;
        off_d   = off_q + REG_AW'(1);
        rem_d   = scan_clr;
        state_d = (scan_clr != '0) ? StWalk : StIdle;
      end
    end else if (accept) begin
      case (opcode)
        OP_ADD, OP_NDU: begin
          we_d    = 1'b1;
          waddr_d = mem_wb_ir[5:3];
        end
        OP_ADI: begin
          we_d    = 1'b1;
          waddr_d = mem_wb_ir[8:6];
        end
        OP_LHI: begin
          we_d    = 1'b1;
          waddr_d = mem_wb_ir[11:9];
          sel_d   = WB_IMM;
        end
        OP_LW: begin
          we_d    = 1'b1;
          waddr_d = mem_wb_ir[11:9];
          sel_d   = WB_MEM;
        end
        OP_JAL, OP_JLR: begin
          we_d    = 1'b1;
          waddr_d = mem_wb_ir[11:9];
          sel_d   = WB_PC2;
        end
        OP_LM: begin
          // Empty mask degenerates to a NOP.
          if (scan_found) begin
            we_d    = 1'b1;
            waddr_d = scan_idx;
            sel_d   = WB_MEM;
            rem_d   = scan_clr;
            state_d = (scan_clr != '0) ? StWalk : StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      sel_q   <= WB_ALU;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
    end
  end

  assign wb_ready   = (state_q == StIdle);
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign wb_src_sel = sel_q;
  assign lm_offset  = off_q;

endmodule

// File: tb/tb_wb_control_unit.sv
// Directed vector bench for wb_control_unit: table of single-edge vectors plus
// hand-written reset sequences.
module tb_wb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mem_wb_valid;
  logic [15:0] mem_wb_ir;
  logic        wb_ready;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [1:0]  wb_src_sel;
  logic [2:0]  lm_offset;

  int n_vec;
  int n_bad;

  typedef struct {
    string       name;
    logic        flush;
    logic        valid;
    logic [15:0] ir;
    logic        rdy;
    logic        we;
    logic [2:0]  wa;
    logic [1:0]  sel;
    logic [2:0]  off;
  } vec_t;

  vec_t vecs[$];

  wb_control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ir    (mem_wb_ir),
    .wb_ready     (wb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .wb_src_sel   (wb_src_sel),
    .lm_offset    (lm_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic fl, logic v, logic [15:0] ir, logic rdy,
                              logic we, logic [2:0] wa, logic [1:0] sel, logic [2:0] off);
    vec_t r;
    r.name = name; r.flush = fl; r.valid = v; r.ir = ir;
    r.rdy = rdy; r.we = we; r.wa = wa; r.sel = sel; r.off = off;
    return r;
  endfunction

  task automatic check(string name, logic rdy, logic we, logic [2:0] wa, logic [1:0] sel,
                       logic [2:0] off);
    n_vec++;
    if (wb_ready !== rdy || rf_we !== we || rf_waddr !== wa || wb_src_sel !== sel ||
        lm_offset !== off) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b we=%b wa=%0d sel=%0d off=%0d, want rdy=%b we=%b wa=%0d sel=%0d off=%0d",
               name, wb_ready, rf_we, rf_waddr, wb_src_sel, lm_offset, rdy, we, wa, sel, off);
    end
  endtask

  // Called just after a rising edge; drives inputs, takes one edge, checks.
  task automatic apply(vec_t v);
    flush        = v.flush;
    mem_wb_valid = v.valid;
    mem_wb_ir    = v.ir;
    @(posedge clk);
    #1;
    check(v.name, v.rdy, v.we, v.wa, v.sel, v.off);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    mem_wb_valid = 1'b0;
    mem_wb_ir = 16'h0000;

    //           name          fl  v   ir       rdy we wa sel off
    vecs.push_back(mk("lw_r3",     0, 1, 16'h4600, 1, 1, 3, 1, 0));
    vecs.push_back(mk("add_r5",    0, 1, 16'h1028, 1, 1, 5, 0, 0));
    vecs.push_back(mk("jal_r2",    0, 1, 16'h9400, 1, 1, 2, 2, 0));
    vecs.push_back(mk("lhi_r7",    0, 1, 16'h3E00, 1, 1, 7, 3, 0));
    vecs.push_back(mk("idle_nv",   0, 0, 16'h4600, 1, 0, 0, 0, 0));
    vecs.push_back(mk("lm05_r0",   0, 1, 16'h6005, 0, 1, 0, 1, 0));
    vecs.push_back(mk("lm05_r2",   0, 1, 16'h4200, 1, 1, 2, 1, 1));
    vecs.push_back(mk("lw_r1",     0, 1, 16'h4200, 1, 1, 1, 1, 0));
    vecs.push_back(mk("lmff_r0",   0, 1, 16'h60FF, 0, 1, 0, 1, 0));
    vecs.push_back(mk("lmff_r1",   0, 1, 16'h60FF, 0, 1, 1, 1, 1));
    vecs.push_back(mk("lmff_r2",   0, 1, 16'h60FF, 0, 1, 2, 1, 2));
    vecs.push_back(mk("lmff_r3",   0, 1, 16'h60FF, 0, 1, 3, 1, 3));
    vecs.push_back(mk("lmff_r4",   0, 1, 16'h60FF, 0, 1, 4, 1, 4));
    vecs.push_back(mk("lmff_r5",   0, 1, 16'h60FF, 0, 1, 5, 1, 5));
    vecs.push_back(mk("lmff_r6",   0, 1, 16'h60FF, 0, 1, 6, 1, 6));
    vecs.push_back(mk("lmff_r7",   0, 1, 16'h6000, 1, 1, 7, 1, 7));
    vecs.push_back(mk("lm00_nop",  0, 1, 16'h6000, 1, 0, 0, 0, 0));
    vecs.push_back(mk("lm0e_r1",   0, 1, 16'h600E, 0, 1, 1, 1, 0));
    vecs.push_back(mk("lm0e_fl",   1, 1, 16'h600E, 1, 0, 0, 0, 0));
    vecs.push_back(mk("sw_nop",    0, 1, 16'h5000, 1, 0, 0, 0, 0));
    vecs.push_back(mk("adi_r7",    0, 1, 16'h01C0, 1, 1, 7, 0, 0));
    vecs.push_back(mk("ndu_r2",    0, 1, 16'h2010, 1, 1, 2, 0, 0));
    vecs.push_back(mk("jlr_r3",    0, 1, 16'hA600, 1, 1, 3, 2, 0));
    vecs.push_back(mk("flush_lw",  1, 1, 16'h4600, 1, 0, 0, 0, 0));
    vecs.push_back(mk("undef_op",  0, 1, 16'hF123, 1, 0, 0, 0, 0));
    vecs.push_back(mk("lm80_r7",   0, 1, 16'h6080, 1, 1, 7, 1, 0));

    #3;
    check("reset_state", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-walk, away from any clock edge.
    apply(mk("lmf0_r4", 0, 1, 16'h60F0, 0, 1, 4, 1, 0));
    apply(mk("lmf0_r5", 0, 1, 16'h60F0, 0, 1, 5, 1, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    mem_wb_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", 1, 0, 0, 0, 0);
    apply(mk("post_rst_lw_r4", 0, 1, 16'h4800, 1, 1, 4, 1, 0));
    apply(mk("tail_nv", 0, 0, 16'h0000, 1, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_control_unit.md
Name: wb_control_unit

Overview:
Writeback-stage control for the 16-bit pipeline. It decodes the MEM/WB instruction into a registered writeback source select, a register-file write enable and a destination address. It also sequences multi-cycle LM (load multiple) writebacks by walking the register mask, one register per cycle. A valid/ready handshake back-pressures the MEM/WB latch while an LM walk is in progress.

Parameters:
IR_W, 16, instruction width
OP_W, 4, opcode width (opcode = IR[IR_W-1 -: OP_W])
REG_AW, 3, register address width; register count = 2**REG_AW
MASK_W, 8, LM mask width (must equal 2**REG_AW); mask = IR[MASK_W-1:0]
OP_ADI / OP_ADD / OP_NDU / OP_LHI, 0000 / 0001 / 0010 / 0011, opcodes
OP_LW / OP_LM / OP_JAL / OP_JLR, 0100 / 0110 / 1001 / 1010, opcodes

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
flush  in  1  synchronous kill of current/pending writeback
mem_wb_valid  in  1  MEM/WB latch holds a valid instruction
mem_wb_ir  in  IR_W  MEM/WB instruction register
wb_ready  out  1  block accepts an instruction at the next edge (registered)
rf_we  out  1  register-file write enable
rf_waddr  out  REG_AW  destination register
wb_src_sel  out  2  writeback source: 0=ALU_C, 1=MEM_DOUT, 2=PC+2, 3=IMM
lm_offset  out  REG_AW  LM word index for the current write (0,1,2,...)

Behaviour:
- Reset (async, rst_n=0): state IDLE, wb_ready=1, rf_we=0, rf_waddr=0, wb_src_sel=0, lm_offset=0, remaining mask=0. Reset mid-walk abandons the walk.
- Handshake: accept = mem_wb_valid & wb_ready. wb_ready = (state==IDLE), driven from a register with no combinational path from inputs. Upstream holds MEM/WB while wb_ready=0.
- All outputs are registered. The effect of an accepted instruction appears one cycle after the accepting edge.
- Decode on accept (IDLE). The outputs below take effect at the next edge:
  - ADD/NDU: we=1, waddr=IR[5:3], sel=0.
  - ADI: we=1, waddr=IR[8:6], sel=0.
  - LHI: we=1, waddr=IR[11:9], sel=3.
  - LW: we=1, waddr=IR[11:9], sel=1.
  - JAL/JLR: we=1, waddr=IR[11:9], sel=2.
  - Any other opcode (SW, SM, branches, undefined): we=0, sel=0, waddr=0.
  - lm_offset=0 for all non-LM instructions.
- LM on accept with mask M≠0:
  - Emit the lowest set bit k of M: we=1, waddr=k, sel=1, lm_offset=0.
  - Remaining mask R = M with bit k cleared. If R≠0, go to WALK (wb_ready=0); otherwise stay IDLE.
- LM with M=0: treated as a NOP (we=0); no WALK.
- WALK, each edge:
  - Emit the lowest set bit k of R: we=1, waddr=k, sel=1, lm_offset=previous+1.
  - Clear bit k. When R becomes 0, go to IDLE (wb_ready=1 from the next cycle).
  - mem_wb_ir and mem_wb_valid are ignored in WALK.
- Bit-to-register mapping: mask bit i maps to register Ri, ascending order. An LM with N set bits holds wb_ready low for N-1 cycles and produces N consecutive write cycles.
- lm_offset wraps modulo 2**REG_AW. It cannot overflow, because N ≤ MASK_W.
- flush=1 at an edge: next outputs we=0, sel=0, lm_offset=0; state IDLE; R cleared. flush has priority over accept and WALK. The instruction presented in that cycle is not accepted.
- If mem_wb_valid=0 in IDLE: we=0, sel=0, waddr=0, lm_offset=0.

Decomposition:
- Shared package wb_pkg holds:
  - opcode localparams;
  - wb_src_sel encodings (WB_ALU=0, WB_MEM=1, WB_PC2=2, WB_IMM=3);
  - state encoding (IDLE, WALK).
- One sub-module, lm_mask_scan (combinational, MASK_W-parameterised): given a mask, outputs found, the lowest set-bit index (REG_AW), and the mask with that bit cleared. It is instantiated once and shared between the accept path and the WALK path.

Test Plan:
- Reset then LW R3 (IR=0x4600), valid=1 → next cycle we=1, waddr=3, sel=1, offset=0; wb_ready stays 1.
- Back-to-back ADD R5 (IR=0x1028), JAL R2 (IR=0x9400), LHI R7 (IR=0x3E00) → consecutive cycles: (we=1, waddr=5, sel=0), (we=1, waddr=2, sel=2), (we=1, waddr=7, sel=3).
- LM mask 0x05 followed by LW R1 held on input → writes R0 (offset 0) then R2 (offset 1). wb_ready=0 for exactly 1 cycle. The LW write to R1 appears in the cycle after R2.
- LM mask 0xFF → 8 consecutive writes R0..R7, offsets 0..7, wb_ready low for 7 cycles. Then LM mask 0x00 → we=0 and wb_ready stays 1.
- LM mask 0x0E; flush asserted on the edge after R1 is written → no R2/R3 writes, we=0 next cycle, wb_ready=1. A new SW gives we=0.
- LM mask 0xF0 with rst_n pulsed low asynchronously mid-walk (between edges) → outputs zero immediately, wb_ready=1. After release, LW R4 behaves normally.
